// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
// States, grant ids, the latched request bundle, counter sizing.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_t;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 255;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  // Counter width able to hold lim itself plus headroom.
  function automatic int cnt_w(input int lim);
    return $clog2(lim + 2);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Data-first priority decision with a fetch starvation guard.
// Counter only moves while the arbiter is idle.
module arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en_i,
  input  logic inst_req_i,
  input  logic data_req_i,
  output logic gnt_vld_o,
  output logic gnt_sel_o
);

  localparam int CW = cnt_w(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starved;

  always_comb begin
    starved   = (cnt_q == CW'(STARVE_LIMIT));
    gnt_vld_o = arb_en_i & (inst_req_i | data_req_i);
    gnt_sel_o = GNT_INST;
    if (data_req_i && !(inst_req_i && starved))
      gnt_sel_o = GNT_DATA;
    cnt_d = cnt_q;
    if (arb_en_i) begin
      // Only a data win over a waiting fetch counts.
      if (!inst_req_i || gnt_sel_o == GNT_INST)
        cnt_d = '0;
      else
        cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data-memory stages.
// IDLE arbitrates, BUSY waits for mem_ready, RESP pulses one ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ack,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout_err
);

  localparam int TW = cnt_w(TIMEOUT);

  state_t        state_q, state_d;
  gnt_t          gnt_q, gnt_d;
  mreq_t         req_q, req_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [31:0]   irdata_q, irdata_d;
  logic [31:0]   drdata_q, drdata_d;
  logic          terr_q, terr_d;
  logic          arb_en;
  logic          gnt_vld;
  logic          gnt_sel;
  logic [31:0]   resp_data;

  assign arb_en = (state_q == ST_IDLE);

  arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .reset      (reset),
    .arb_en_i   (arb_en),
    .inst_req_i (inst_req),
    .data_req_i (data_req),
    .gnt_vld_o  (gnt_vld),
    .gnt_sel_o  (gnt_sel)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    req_d     = req_q;
    tcnt_d    = tcnt_q;
    irdata_d  = irdata_q;
    drdata_d  = drdata_q;
    terr_d    = terr_q;
    resp_data = mem_rdata;
    if (gnt_q == GNT_DATA && req_q.we)
      resp_data = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_d = ST_BUSY;
          gnt_d   = gnt_t'(gnt_sel);
          tcnt_d  = '0;
          if (gnt_sel == GNT_DATA)
            req_d = '{we: data_we, addr: data_addr,
                      wdata: data_wdata};
          else
            req_d = '{we: 1'b0, addr: inst_addr,
                      wdata: 32'h0};
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          state_d = ST_RESP;
        end else if (tcnt_q == TW'(TIMEOUT)) begin
          state_d   = ST_RESP;
          resp_data = '0;
          terr_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
        if (state_d == ST_RESP) begin
          if (gnt_q == GNT_DATA) drdata_d = resp_data;
          else                   irdata_d = resp_data;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= GNT_INST;
      req_q    <= '0;
      tcnt_q   <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      req_q    <= req_d;
      tcnt_q   <= tcnt_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      terr_q   <= terr_d;
    end
  end

  assign mem_req     = (state_q == ST_BUSY);
  assign mem_we      = req_q.we;
  assign mem_addr    = req_q.addr;
  assign mem_wdata   = req_q.wdata;
  assign inst_ack    = (state_q == ST_RESP) && (gnt_q == GNT_INST);
  assign data_ack    = (state_q == ST_RESP) && (gnt_q == GNT_DATA);
  assign inst_rdata  = irdata_q;
  assign data_rdata  = drdata_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus
// a randomized run against a transaction-schedule model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_we, mem_ready;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic        inst_ack, data_ack, mem_req, mem_we, timeout_err;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;

  int checks   = 0;
  int failures = 0;

  mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .inst_ack    (inst_ack),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_ack    (data_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req   = 1'b0;
    inst_addr  = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    checks++;
    if ({mem_req, mem_we, inst_ack, data_ack, timeout_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl: got %b want 00000",
               {mem_req, mem_we, inst_ack, data_ack, timeout_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, inst_rdata, data_rdata} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data: got %h %h %h %h want all 0",
               mem_addr, mem_wdata, inst_rdata, data_rdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_inst_only();
    do_reset();
    inst_req  = 1'b1;
    inst_addr = 32'h0040_0000;
    tick();
    checks++;
    if ({mem_req, mem_we, inst_ack, data_ack} !== 4'b1000 ||
        mem_addr !== 32'h0040_0000) begin
      failures++;
      $display("FAIL inst_c1: got req/we/ia/da=%b addr=%h want 1000 00400000",
               {mem_req, mem_we, inst_ack, data_ack}, mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h8C08_0004;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    checks++;
    if ({mem_req, inst_ack, data_ack} !== 3'b010) begin
      failures++;
      $display("FAIL inst_c2: got req/ia/da=%b want 010",
               {mem_req, inst_ack, data_ack});
    end
    checks++;
    if (inst_rdata !== 32'h8C08_0004) begin
      failures++;
      $display("FAIL inst_rdata: got %h want 8c080004", inst_rdata);
    end
    inst_req = 1'b0;
    tick();
    checks++;
    if ({mem_req, inst_ack, data_ack} !== 3'b000 ||
        inst_rdata !== 32'h8C08_0004) begin
      failures++;
      $display("FAIL inst_c3: got req/ia/da=%b rdata=%h want 000 8c080004",
               {mem_req, inst_ack, data_ack}, inst_rdata);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    inst_req   = 1'b1;
    inst_addr  = 32'h0040_0004;
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 32'h1001_0000;
    data_wdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h1001_0000 ||
        mem_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL sim_data_grant: got req/we=%b addr=%h wd=%h want 11 10010000 deadbeef",
               {mem_req, mem_we}, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    checks++;
    if ({inst_ack, data_ack} !== 2'b01 || data_rdata !== 32'h0) begin
      failures++;
      $display("FAIL sim_data_ack: got ia/da=%b rdata=%h want 01 00000000",
               {inst_ack, data_ack}, data_rdata);
    end
    data_req = 1'b0;
    tick();
    checks++;
    if ({mem_req, inst_ack, data_ack} !== 3'b000) begin
      failures++;
      $display("FAIL sim_idle: got req/ia/da=%b want 000",
               {mem_req, inst_ack, data_ack});
    end
    mem_rdata = 32'h0123_4567;
    tick();
    checks++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h0040_0004 ||
        mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL sim_inst_grant: got req/we=%b addr=%h wd=%h want 10 00400004 0",
               {mem_req, mem_we}, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if ({inst_ack, data_ack} !== 2'b10 || inst_rdata !== 32'h0123_4567) begin
      failures++;
      $display("FAIL sim_inst_ack: got ia/da=%b rdata=%h want 10 01234567",
               {inst_ack, data_ack}, inst_rdata);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    inst_req  = 1'b1;
    inst_addr = 32'h0040_0100;
    data_req  = 1'b1;
    data_addr = 32'h1001_0040;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    for (int c = 1; c <= 30; c++) begin
      logic [1:0] exp;
      tick();
      exp = 2'b00;
      // grants every 3 cycles; every fifth one goes to fetch
      if (c >= 2 && (c - 2) % 3 == 0)
        exp = (((c - 2) / 3) % 5 == 4) ? 2'b10 : 2'b01;
      checks++;
      if ({inst_ack, data_ack} !== exp) begin
        failures++;
        $display("FAIL starve c=%0d: got ia/da=%b want %b",
                 c, {inst_ack, data_ack}, exp);
      end
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    data_req  = 1'b1;
    data_addr = 32'h1001_0100;
    mem_rdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 259; c++) begin
      logic [3:0] exp;
      tick();
      exp = {(c <= 256), 1'b0, (c == 257), (c >= 257)};
      checks++;
      if ({mem_req, inst_ack, data_ack, timeout_err} !== exp) begin
        failures++;
        $display("FAIL timeout c=%0d: got req/ia/da/err=%b want %b",
                 c, {mem_req, inst_ack, data_ack, timeout_err}, exp);
      end
      if (c == 257) begin
        checks++;
        if (data_rdata !== 32'h0) begin
          failures++;
          $display("FAIL timeout_rdata: got %h want 0", data_rdata);
        end
        data_req = 1'b0;
      end
    end
    for (int n = 0; n < 100; n++) begin
      logic [31:0] v;
      v         = $urandom;
      inst_req  = 1'b1;
      inst_addr = 32'(n) << 2;
      tick();
      mem_ready = 1'b1;
      mem_rdata = v;
      tick();
      checks++;
      if ({inst_ack, timeout_err} !== 2'b11 || inst_rdata !== v) begin
        failures++;
        $display("FAIL sticky n=%0d: got ack/err=%b rdata=%h want 11 %h",
                 n, {inst_ack, timeout_err}, inst_rdata, v);
      end
      inst_req  = 1'b0;
      mem_ready = 1'b0;
      tick();
    end
  endtask

  task automatic test_async_reset();
    data_req  = 1'b1;
    data_addr = 32'h1001_0200;
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({mem_req, timeout_err} !== 2'b11) begin
      failures++;
      $display("FAIL areset_pre: got req/err=%b want 11",
               {mem_req, timeout_err});
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, inst_ack, data_ack, timeout_err} !== 4'b0 ||
        mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL areset_drop: got req/ia/da/err=%b addr=%h want 0000 0",
               {mem_req, inst_ack, data_ack, timeout_err}, mem_addr);
    end
    clear_inputs();
    #2;
    reset = 1'b0;
    tick();
    inst_req  = 1'b1;
    inst_addr = 32'h0040_0200;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0200) begin
      failures++;
      $display("FAIL areset_c1: got req=%b addr=%h want 1 00400200",
               mem_req, mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h2402_0001;
    tick();
    checks++;
    if ({inst_ack, data_ack} !== 2'b10 || inst_rdata !== 32'h2402_0001) begin
      failures++;
      $display("FAIL areset_c2: got ia/da=%b rdata=%h want 10 24020001",
               {inst_ack, data_ack}, inst_rdata);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_spurious();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      tick();
      checks++;
      if ({mem_req, inst_ack, data_ack} !== 3'b000 ||
          {inst_rdata, data_rdata} !== 64'h0) begin
        failures++;
        $display("FAIL spur_idle c=%0d: got req/ia/da=%b rd=%h/%h want 000 0/0",
                 c, {mem_req, inst_ack, data_ack}, inst_rdata, data_rdata);
      end
    end
    inst_req  = 1'b1;
    inst_addr = 32'h0040_0300;
    mem_rdata = 32'h1111_2222;
    tick();
    tick();
    checks++;
    if ({inst_ack, data_ack} !== 2'b10) begin
      failures++;
      $display("FAIL spur_ack: got ia/da=%b want 10", {inst_ack, data_ack});
    end
    for (int c = 3; c <= 6; c++) begin
      tick();
      inst_req = 1'b0;
      checks++;
      if ({mem_req, inst_ack, data_ack} !== 3'b000) begin
        failures++;
        $display("FAIL spur_hold c=%0d: got req/ia/da=%b want 000",
                 c, {mem_req, inst_ack, data_ack});
      end
    end
    clear_inputs();
  endtask

  // Schedule model: a grant at cycle g with d wait cycles owns the
  // port for g+1..g+1+d, acks at g+2+d, and frees IDLE at g+3+d.
  task automatic test_random();
    int          idle_from, g_start, g_d, starve;
    bit          active, g_data, g_we;
    logic [31:0] g_addr, g_wdata, g_rdata;
    logic [31:0] exp_ir, exp_dr;
    bit          ipend, dpend, dwe;
    logic [31:0] ia, da, dw;
    do_reset();
    idle_from = 0;
    g_start   = 0;
    g_d       = 0;
    starve    = 0;
    active    = 0;
    g_data    = 0;
    g_we      = 0;
    g_addr    = '0;
    g_wdata   = '0;
    g_rdata   = '0;
    exp_ir    = '0;
    exp_dr    = '0;
    ipend     = 0;
    dpend     = 0;
    dwe       = 0;
    ia        = '0;
    da        = '0;
    dw        = '0;
    for (int c = 0; c < 1500; c++) begin
      bit exp_busy, exp_ack, rdy_now;
      exp_busy = active && c >= g_start + 1 && c <= g_start + 1 + g_d;
      exp_ack  = active && c == g_start + 2 + g_d;
      rdy_now  = active && c == g_start + 1 + g_d;
      if (exp_ack) begin
        if (g_data) exp_dr = g_rdata;
        else        exp_ir = g_rdata;
      end
      checks++;
      if ({mem_req, inst_ack, data_ack} !==
          {exp_busy, exp_ack & !g_data, exp_ack & g_data}) begin
        failures++;
        $display("FAIL rnd_ctl c=%0d: got req/ia/da=%b want %b",
                 c, {mem_req, inst_ack, data_ack},
                 {exp_busy, exp_ack & !g_data, exp_ack & g_data});
      end
      if (exp_busy) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {g_we, g_addr, g_wdata}) begin
          failures++;
          $display("FAIL rnd_bus c=%0d: got we=%b a=%h wd=%h want %b %h %h",
                   c, mem_we, mem_addr, mem_wdata, g_we, g_addr, g_wdata);
        end
      end
      checks++;
      if (inst_rdata !== exp_ir || data_rdata !== exp_dr) begin
        failures++;
        $display("FAIL rnd_rdata c=%0d: got %h/%h want %h/%h",
                 c, inst_rdata, data_rdata, exp_ir, exp_dr);
      end
      if (exp_ack) begin
        active = 0;
        if (g_data) dpend = 0;
        else        ipend = 0;
      end
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1;
        ia    = $urandom;
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1;
        da    = $urandom;
        dw    = $urandom;
        dwe   = 1'($urandom_range(0, 1));
      end
      inst_req   = ipend;
      inst_addr  = ia;
      data_req   = dpend;
      data_addr  = da;
      data_wdata = dw;
      data_we    = dwe;
      mem_rdata  = $urandom;
      if (rdy_now) begin
        mem_ready = 1'b1;
        g_rdata   = (g_data && g_we) ? 32'h0 : mem_rdata;
      end else if (exp_busy) begin
        mem_ready = 1'b0;
      end else begin
        mem_ready = ($urandom_range(0, 3) == 0);
      end
      if (!active && c >= idle_from) begin
        if (ipend || dpend) begin
          g_data    = dpend && !(ipend && starve == 4);
          starve    = (ipend && g_data) ? starve + 1 : 0;
          active    = 1;
          g_start   = c;
          g_d       = $urandom_range(0, 3);
          g_we      = g_data ? dwe : 1'b0;
          g_addr    = g_data ? da : ia;
          g_wdata   = g_data ? dw : 32'h0;
          idle_from = c + 3 + g_d;
        end else begin
          starve = 0;
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_inst_only();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_async_reset();
    test_spurious();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external memory port between the instruction-fetch stage and the data-memory (M) stage of the pipelined MIPS core.
- Generates the per-requester acknowledges that the core consumes as inst_mem_ack_F and data_mem_ack_M.
- Data accesses have priority; a starvation guard bounds how long fetch can wait.
- A timeout guard keeps a hung memory from locking the pipeline.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while inst_req is pending before fetch is forced.
- TIMEOUT, 255: cycles in BUSY without mem_ready before the transaction is aborted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request; held until inst_ack
- inst_addr  in  32  fetch address (pc_F)
- inst_rdata  out  32  fetched instruction, valid while inst_ack=1
- inst_ack  out  1  one-cycle completion pulse to fetch
- data_req  in  1  data request; held until data_ack
- data_we  in  1  1=write, 0=read
- data_addr  in  32  data address (alu_out_M)
- data_wdata  in  32  write data (write_data_M)
- data_rdata  out  32  read data, valid while data_ack=1
- data_ack  out  1  one-cycle completion pulse to M stage
- mem_req  out  1  external memory request
- mem_we  out  1  external write enable
- mem_addr  out  32  external address
- mem_wdata  out  32  external write data
- mem_rdata  in  32  external read data, valid with mem_ready
- mem_ready  in  1  external completion
- timeout_err  out  1  sticky abort flag, cleared only by reset

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; starvation counter, timeout counter, grant register all 0. An in-flight transaction is dropped with no ack.
- States:
  - IDLE: arbitrate.
  - BUSY: mem_req=1; mem_addr, mem_we and mem_wdata driven from registers latched at grant and stable for the whole transaction.
  - RESP: exactly one cycle; the granted ack=1 and its rdata is valid.
- IDLE arbitration, evaluated each cycle:
  - data_req only -> grant data.
  - inst_req only -> grant inst.
  - Both, starvation counter < STARVE_LIMIT -> grant data, counter+1.
  - Both, counter == STARVE_LIMIT -> grant inst.
  - Counter clears whenever inst is granted or inst_req is low in IDLE.
- On grant: latch address, we (inst grants force we=0) and wdata; go to BUSY next cycle.
- BUSY:
  - mem_ready=1 -> latch mem_rdata into the granted rdata output (data write: rdata=0); go to RESP.
  - Otherwise the timeout counter increments.
  - Counter reaches TIMEOUT -> go to RESP with rdata=0 and set timeout_err.
  - Timeout counter clears on entering BUSY.
- RESP -> IDLE unconditionally. Requests are not sampled in RESP, so a held req is never double-granted.
- Minimum latency: req seen in IDLE at cycle 0, mem_req cycle 1, mem_ready cycle 1, ack cycle 2. Back-to-back grant period: 3 cycles.
- mem_ready outside BUSY is ignored.
- Requests dropped while in BUSY do not abort; the ack is still issued.
- rdata outputs hold their last value when ack=0; only the ack qualifies them.

Decomposition:
- Shared package mem_arb_pkg: state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), grant encoding (GNT_INST=1'b0, GNT_DATA=1'b1), default parameter constants.
- One sub-module: arb_prio, a combinational priority and starvation decision with registered counter, instantiated once.

Test Plan:
- Inst-only read of 0x00400000, mem_ready on first BUSY cycle, mem_rdata=0x8C080004 -> mem_req in cycle 1 only; inst_ack in cycle 2 with inst_rdata=0x8C080004; data_ack never asserted.
- Simultaneous inst_req and data_req (write 0xDEADBEEF to 0x10010000) -> data granted first with mem_we=1 and mem_wdata=0xDEADBEEF; inst granted on the following IDLE; acks 3 cycles apart.
- inst_req held plus data_req re-asserted every IDLE with STARVE_LIMIT=4 -> exactly 4 data acks, then an inst ack, then the counter restarts at 0.
- mem_ready held low with TIMEOUT=255 -> ack issued 256 cycles after BUSY entry, rdata=0, timeout_err=1 and still 1 after 100 further normal transactions.
- Reset asserted mid-BUSY, asynchronously between clock edges -> mem_req, acks and timeout_err drop to 0 immediately; after release, the next request completes with normal 2-cycle latency.
- mem_ready pulsed while IDLE, and req held through RESP -> no spurious ack; exactly one ack per grant.
